// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte-wide register file and auto-incrementing pointer.
// SCL/SDA are oversampled on PCLK; SDA is driven open-drain through sda_oe.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         REG_DEPTH  = 16,
    parameter int         PTR_W      = $clog2(REG_DEPTH)
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic             wr_valid,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_IGNORE,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WRITE,
        ST_WR_ACK,
        ST_READ,
        ST_MACK
    } state_t;

    state_t             state;
    logic [3:0]         bit_cnt;
    logic [7:0]         shift_reg;
    logic               rw;
    logic [PTR_W-1:0]   ptr;
    logic [7:0]         regs [REG_DEPTH];

    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;

    // Synchronizers reset to the idle-bus level so reset release never looks like an edge.
    // NOTE: every sequential assignment uses <= so all flops sample the same pre-edge values.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    logic             scl_rise;
    logic             scl_fall;
    logic             start_det;
    logic             stop_det;
    logic [7:0]       rx_byte;
    logic [PTR_W-1:0] ptr_inc;

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign rx_byte   = {shift_reg[6:0], sda_s2};
    assign ptr_inc   = ptr + PTR_W'(1);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rw        <= 1'b0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            // NOTE: the register file is small and must read back as zero after reset, so it is built from resettable flops rather than a RAM macro.
            for (int i = 0; i < REG_DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_valid <= 1'b0;
            if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= '0;
                busy    <= 1'b1;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
                busy    <= 1'b0;
                sda_oe  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                    end

                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                if (rx_byte[7:1] == SLAVE_ADDR) begin
                                    rw    <= rx_byte[0];
                                    state <= ST_ADDR_ACK;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    ST_IGNORE: begin
                        sda_oe <= 1'b0;
                    end

                    // ACK states are entered with SDA released, so sda_oe doubles as the phase flag.
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else if (rw) begin
                                sda_oe    <= ~regs[ptr][7];
                                shift_reg <= {regs[ptr][6:0], 1'b0};
                                bit_cnt   <= 4'd1;
                                state     <= ST_READ;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= ST_PTR;
                            end
                        end
                    end

                    ST_PTR: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                ptr     <= rx_byte[PTR_W-1:0];
                                state   <= ST_PTR_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    ST_PTR_ACK, ST_WR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= ST_WRITE;
                            end
                        end
                    end

                    ST_WRITE: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt    <= '0;
                                regs[ptr]  <= rx_byte;
                                wr_valid   <= 1'b1;
                                wr_addr    <= ptr;
                                wr_data    <= rx_byte;
                                ptr        <= ptr_inc;
                                state      <= ST_WR_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    ST_READ: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= ST_MACK;
                            end else begin
                                sda_oe    <= ~shift_reg[7];
                                shift_reg <= {shift_reg[6:0], 1'b0};
                                bit_cnt   <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    // Master ACK continues the burst; first data bit goes out on the next SCL fall.
                    ST_MACK: begin
                        if (scl_rise) begin
                            ptr <= ptr_inc;
                            if (!sda_s2) begin
                                shift_reg <= regs[ptr_inc];
                                bit_cnt   <= '0;
                                state     <= ST_READ;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end

                    default: begin
                        state  <= ST_IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-banged I2C master with an open-drain SDA line.
module tb_i2c_slave_regfile;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       scl_m;
    logic       sda_m;
    logic       sda_oe;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       sda_line;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .REG_DEPTH(16)) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad   = 0;

    logic [3:0] wr_a [$];
    logic [7:0] wr_d [$];
    int         oe_cnt   = 0;
    int         wide_cnt = 0;
    logic       wr_prev  = 1'b0;

    always @(negedge PCLK) begin
        if (wr_valid) begin
            wr_a.push_back(wr_addr);
            wr_d.push_back(wr_data);
        end
        if (wr_valid && wr_prev) wide_cnt++;
        wr_prev = wr_valid;
        if (sda_oe) oe_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (4) @(negedge PCLK);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q();
        s = sda_line; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(nack, s);
    endtask

    // Set pointer, repeated START, read n (1 or 2) bytes, NACK the last, STOP.
    task automatic read_regs(input logic [7:0] p, input int n, output logic [7:0] d0, output logic [7:0] d1);
        logic a;
        d1 = 8'h00;
        i2c_start();
        write_byte(8'hA0, a); check("rd addr_w ack", a, 1'b1);
        write_byte(p, a);     check("rd ptr ack", a, 1'b1);
        i2c_start();
        write_byte(8'hA1, a); check("rd addr_r ack", a, 1'b1);
        read_byte(n == 1, d0);
        if (n > 1) read_byte(1'b1, d1);
        i2c_stop();
    endtask

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] ptr_byte;
        logic [7:0] data;
        logic       exp_ack;
        logic [3:0] exp_addr;
    } wvec_t;

    wvec_t vecs [5];

    initial begin
        logic       a;
        logic [7:0] d0, d1;
        int         wbase, obase;

        vecs[0] = '{8'hA0, 8'h05, 8'h5A, 1'b1, 4'd5};
        vecs[1] = '{8'hA0, 8'h37, 8'hC3, 1'b1, 4'd7};
        vecs[2] = '{8'hA0, 8'h02, 8'h3C, 1'b1, 4'd2};
        vecs[3] = '{8'hA4, 8'h02, 8'hFF, 1'b0, 4'd0};
        vecs[4] = '{8'hA0, 8'h08, 8'h96, 1'b1, 4'd8};

        PRESETn = 1'b0;
        scl_m   = 1'b1;
        sda_m   = 1'b1;
        repeat (4) @(negedge PCLK);
        check("rst sda_oe", sda_oe, 1'b0);
        check("rst wr_valid", wr_valid, 1'b0);
        check("rst wr_addr", wr_addr, 4'd0);
        check("rst wr_data", wr_data, 8'h00);
        check("rst busy", busy, 1'b0);
        PRESETn = 1'b1;
        wait_q();

        // Single-byte writes, including a non-matching address and a pointer with upper bits set.
        for (int i = 0; i < 5; i++) begin
            wbase = wr_a.size();
            i2c_start();
            write_byte(vecs[i].addr_byte, a); check("vec addr ack", a, vecs[i].exp_ack);
            write_byte(vecs[i].ptr_byte, a);  check("vec ptr ack", a, vecs[i].exp_ack);
            write_byte(vecs[i].data, a);      check("vec data ack", a, vecs[i].exp_ack);
            i2c_stop();
            wait_q();
            check("vec wr count", wr_a.size() - wbase, vecs[i].exp_ack ? 1 : 0);
            if (vecs[i].exp_ack && wr_a.size() > wbase) begin
                check("vec wr_addr", wr_a[wbase], vecs[i].exp_addr);
                check("vec wr_data", wr_d[wbase], vecs[i].data);
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].exp_ack) begin
                read_regs(vecs[i].ptr_byte, 1, d0, d1);
                check("vec readback", d0, vecs[i].data);
            end
        end

        // Write burst.
        wbase = wr_a.size();
        i2c_start();
        write_byte(8'hA0, a); check("burst addr ack", a, 1'b1);
        check("burst busy", busy, 1'b1);
        write_byte(8'h03, a); check("burst ptr ack", a, 1'b1);
        write_byte(8'h11, a); check("burst d0 ack", a, 1'b1);
        write_byte(8'h22, a); check("burst d1 ack", a, 1'b1);
        i2c_stop();
        wait_q();
        check("burst busy after stop", busy, 1'b0);
        check("burst wr count", wr_a.size() - wbase, 2);
        if (wr_a.size() - wbase == 2) begin
            check("burst wr_addr0", wr_a[wbase], 4'd3);
            check("burst wr_data0", wr_d[wbase], 8'h11);
            check("burst wr_addr1", wr_a[wbase+1], 4'd4);
            check("burst wr_data1", wr_d[wbase+1], 8'h22);
        end

        // Combined read, then a current-address read proves the pointer moved to 5.
        i2c_start();
        write_byte(8'hA0, a); check("cr addr ack", a, 1'b1);
        write_byte(8'h03, a); check("cr ptr ack", a, 1'b1);
        i2c_start();
        write_byte(8'hA1, a); check("cr addr_r ack", a, 1'b1);
        read_byte(1'b0, d0);  check("cr byte0", d0, 8'h11);
        read_byte(1'b1, d1);  check("cr byte1", d1, 8'h22);
        check("cr sda_oe after nack", sda_oe, 1'b0);
        i2c_stop();
        i2c_start();
        write_byte(8'hA1, a); check("cur addr ack", a, 1'b1);
        read_byte(1'b1, d0);  check("cur byte ptr5", d0, 8'h5A);
        i2c_stop();

        // Wrap-around.
        wbase = wr_a.size();
        i2c_start();
        write_byte(8'hA0, a); write_byte(8'h0F, a);
        write_byte(8'hAA, a); check("wrap d0 ack", a, 1'b1);
        write_byte(8'hBB, a); check("wrap d1 ack", a, 1'b1);
        i2c_stop();
        wait_q();
        check("wrap wr count", wr_a.size() - wbase, 2);
        if (wr_a.size() - wbase == 2) begin
            check("wrap wr_addr0", wr_a[wbase], 4'd15);
            check("wrap wr_addr1", wr_a[wbase+1], 4'd0);
        end
        read_regs(8'h0F, 2, d0, d1);
        check("wrap reg15", d0, 8'hAA);
        check("wrap reg0", d1, 8'hBB);

        // Address mismatch.
        wbase = wr_a.size();
        obase = oe_cnt;
        i2c_start();
        write_byte(8'hA2, a); check("mis addr nack", a, 1'b0);
        write_byte(8'h00, a); check("mis b1 nack", a, 1'b0);
        write_byte(8'hFF, a); check("mis b2 nack", a, 1'b0);
        i2c_stop();
        wait_q();
        check("mis sda_oe cycles", oe_cnt - obase, 0);
        check("mis wr count", wr_a.size() - wbase, 0);
        read_regs(8'h00, 1, d0, d1);
        check("mis reg0 kept", d0, 8'hBB);

        // Abort after four data bits.
        wbase = wr_a.size();
        i2c_start();
        write_byte(8'hA0, a); check("abort addr ack", a, 1'b1);
        write_byte(8'h02, a); check("abort ptr ack", a, 1'b1);
        bit_xfer(1'b1, a); bit_xfer(1'b0, a); bit_xfer(1'b1, a); bit_xfer(1'b0, a);
        i2c_stop();
        wait_q();
        check("abort wr count", wr_a.size() - wbase, 0);
        check("abort busy", busy, 1'b0);
        read_regs(8'h02, 1, d0, d1);
        check("abort reg2 kept", d0, 8'h3C);

        // Reset while the target holds SDA low for bit 7 of 0x11.
        i2c_start();
        write_byte(8'hA0, a);
        write_byte(8'h03, a);
        i2c_start();
        write_byte(8'hA1, a); check("rr addr_r ack", a, 1'b1);
        wait_q();
        check("rr drive before reset", sda_oe, 1'b1);
        PRESETn = 1'b0;
        #1;
        check("rr sda_oe async", sda_oe, 1'b0);
        check("rr busy", busy, 1'b0);
        repeat (3) @(negedge PCLK);
        sda_m = 1'b1;
        scl_m = 1'b1;
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        wait_q();
        read_regs(8'h03, 2, d0, d1);
        check("rr reg3 cleared", d0, 8'h00);
        check("rr reg4 cleared", d1, 8'h00);
        read_regs(8'h05, 1, d0, d1);
        check("rr reg5 cleared", d0, 8'h00);

        check("wr_valid single cycle", wide_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
Synthesizable I2C target that sits directly downstream of the APB-to-I2C master on the shared scl/sda wires. It replaces the behavioural slave model in system-level runs and can be reused as an on-chip peripheral. It decodes a 7-bit address, holds a byte-wide register file with an auto-incrementing pointer, ACKs writes and serves reads. Bus lines are oversampled on PCLK; the block never drives SCL, so clock stretching is not supported.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit target address matched against the first byte after START/Sr.
REG_DEPTH, 16, number of 8-bit registers; power of two, 2..256.
PTR_W, $clog2(REG_DEPTH), register pointer width (derived; do not override).

Ports:
PCLK       input   1      system clock; must be at least 8x SCL frequency.
PRESETn    input   1      asynchronous active-low reset.
scl_in     input   1      SCL line value (asynchronous).
sda_in     input   1      SDA line value (asynchronous).
sda_oe     output  1      1 = pull SDA low; 0 = release (open-drain, pad ties output to 0).
wr_valid   output  1      one-PCLK pulse per register write.
wr_addr    output  PTR_W  register index written (valid with wr_valid).
wr_data    output  8      byte written (valid with wr_valid).
busy       output  1      high from START to STOP.

Behaviour:
- Reset (async, PRESETn low): sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, all registers=0, pointer=0, state=IDLE. Reset during a transfer releases SDA immediately.
- Input path: 2-FF synchronizer on scl_in and sda_in, then one history register for edge detection. Event detection lags the pins by 3 PCLK.
- START/Sr: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Either event is recognised in every state and aborts any partial byte.
- START/Sr: go to ADDR, clear the bit counter, set busy=1.
- STOP: go to IDLE, busy=0, release SDA. The pointer is kept.
- Data bits are sampled on SCL rising edges, MSB first. SDA drive changes only on SCL falling edges.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits. On the 8th bit: if addr[7:1]==SLAVE_ADDR, go to ADDR_ACK and latch R/W. Otherwise go to IGNORE.
  - IGNORE: never drive SDA; wait for START/STOP.
  - ADDR_ACK: sda_oe=1 from the falling edge after bit 8 to the next falling edge. Then go to PTR if W; if R, go to READ and load the shift register with reg[ptr].
  - PTR: shift in 8 bits. pointer <= byte[PTR_W-1:0] (upper bits ignored). Go to PTR_ACK.
  - PTR_ACK: ACK, then go to WRITE.
  - WRITE: shift in 8 bits. On the 8th bit: reg[ptr]<=byte, pulse wr_valid with wr_addr=ptr and wr_data=byte, ptr<=ptr+1 (wraps modulo REG_DEPTH). Go to WR_ACK.
  - WR_ACK: ACK, then return to WRITE.
  - READ: on each falling edge drive sda_oe = ~bit (MSB first). After the 8th bit's falling edge release SDA and go to MACK.
  - MACK: sample SDA on SCL rise. 0 (ACK): ptr<=ptr+1, load reg[ptr+1], go to READ. 1 (NACK): ptr<=ptr+1, go to IGNORE.
- STOP or START mid-byte: partial byte discarded; no write, no wr_valid, no pointer change.
- Every byte ACKed in write mode; the target never NACKs data.
- wr_valid is exactly one PCLK wide; it never occurs outside WRITE.

Test Plan:
- Write burst: START, 0xA0, 0x03, 0x11, 0x22, STOP -> ACK on all 4 bytes; reg[3]=0x11, reg[4]=0x22; two wr_valid pulses (addr 3/0x11, addr 4/0x22); busy drops at STOP.
- Combined read: after the burst, START, 0xA0, 0x03, Sr, 0xA1, read 2 bytes (master ACK then NACK), STOP -> bytes 0x11, 0x22 on SDA; sda_oe=0 after the NACK; pointer=5.
- Address mismatch: START, 0xA2, 0x00, 0xFF, STOP -> no ACK on any byte; sda_oe never 1; no wr_valid; registers unchanged.
- Wrap-around: START, 0xA0, 0x0F, 0xAA, 0xBB, STOP -> reg[15]=0xAA, reg[0]=0xBB; second wr_addr=0.
- Abort: START, 0xA0, 0x02, then 4 data bits, STOP -> reg[2] unchanged; no third wr_valid; state IDLE; next transaction ACKs normally.
- Reset mid-read: assert PRESETn=0 while driving a 0 bit of a read byte -> sda_oe=0 asynchronously; all registers=0; busy=0.
